// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_if
// Description : Request/response bundle between the EX-stage ALU and the
//               iterative divider sequencer (div_seq_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_signed;
  logic             op_rem;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  // ALU side: issues requests and consumes results
  modport master (
    output in_valid, op_signed, op_rem, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Divider side
  modport slave (
    input  in_valid, op_signed, op_rem, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Sequencer for the EX-stage iterative restoring divider
//               (div.w / mod.w / div.wu / mod.wu). WIDTH shift-subtract
//               steps on operand magnitudes, then a sign fix-up, then the
//               result is held until the consumer takes it.
// Option      : DIV_ZERO_FASTPATH_EN - a zero divisor skips the iteration
//               phase and goes straight to fix-up with the same result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_rem_sel;
  logic             r_neg1;
  logic             r_neg2;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_fast;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept = (r_state == S_IDLE) & bus.in_valid & ~flush;

`ifdef DIV_ZERO_FASTPATH_EN
  // Zero divisor: the full iteration would yield quo=all-ones, rem=|src1|
  assign w_fast = (bus.src2 == '0);
`else
  assign w_fast = 1'b0;
`endif

  // Operand magnitudes; two's-complement only for signed ops
  assign w_neg1 = bus.op_signed & bus.src1[WIDTH-1];
  assign w_neg2 = bus.op_signed & bus.src2[WIDTH-1];
  assign w_abs1 = w_neg1 ? -bus.src1 : bus.src1;
  assign w_abs2 = w_neg2 ? -bus.src2 : bus.src2;

  // One restoring step: shifted partial remainder is WIDTH+1 bits so the
  // compare is exact; a successful difference is < divisor and fits WIDTH bits
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_step = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

  // Sign fix-up: quotient takes sign1^sign2, remainder takes the dividend sign
  assign w_quo_fix = (r_signed & (r_neg1 ^ r_neg2)) ? -r_quo : r_quo;
  assign w_rem_fix = (r_signed & r_neg1) ? -r_rem : r_rem;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every transition including the DONE handshake
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.in_valid) w_state_nxt = w_fast ? S_FIX : S_ITER;
        S_ITER:  if (r_cnt == '0)  w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_DONE;
        S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, fix-up into the result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_rem_sel <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_result  <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed  <= bus.op_signed;
            r_rem_sel <= bus.op_rem;
            r_neg1    <= w_neg1;
            r_neg2    <= w_neg2;
            r_div     <= w_abs2;
            r_cnt     <= CNT_W'(WIDTH - 1);
            if (w_fast) begin
              r_quo <= '1;
              r_rem <= w_abs1;
            end else begin
              r_quo <= w_abs1;
              r_rem <= '0;
            end
          end
        end
        S_ITER: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_result <= r_rem_sel ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Self-checking bench for div_seq_ctrl: directed corner cases
//               plus randomized operations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  div_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, zero divisor and overflow handled explicitly
  function automatic logic [31:0] ref_result(input bit s, input bit r,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    if (b == 32'd0) begin
      q = (s && sa < 0) ? 64'sd1 : -64'sd1;
      m = sa;
    end else begin
      q = sa / sb;
      m = sa % sb;
    end
    return r ? m[31:0] : q[31:0];
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
    return (b == 32'd0) ? 2 : WIDTH + 2;
`else
    return WIDTH + 2;
`endif
  endfunction

  // Present one request for one edge; returns #1 after the accept edge (cycle 1)
  task automatic start_op(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b);
    bus.op_signed = s;
    bus.op_rem    = r;
    bus.src1      = a;
    bus.src2      = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  // Count cycles until out_valid; bounded so a dead DUT still reaches the summary
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input bit s, input bit r,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    start_op(s, r, a, b);
    wait_valid(cyc);
    check({tag, " latency"}, cyc, exp_lat(b));
    check({tag, " result"}, bus.result, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " back to idle"}, bus.in_ready, 32'd1);
  endtask

  initial begin
    int cyc;
    bit seen;
    bit s, r;
    logic [31:0] a, b;

    bus.in_valid  = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", bus.in_ready, 32'd1);
    check("rst out_valid", bus.out_valid, 32'd0);
    check("rst busy", bus.busy, 32'd0);
    check("rst result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Unsigned quotient and remainder
    run_op("u100/7 q", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
    run_op("u100/7 r", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2);

    // Reset mid-iteration: everything back to reset values
    start_op(1'b0, 1'b0, 32'd12345, 32'd17);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("midrst busy", bus.busy, 32'd0);
    check("midrst in_ready", bus.in_ready, 32'd1);
    check("midrst out_valid", bus.out_valid, 32'd0);
    check("midrst result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Signed directed cases
    run_op("s-7/2 q", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("s-7/2 r", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("s ovf q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("s ovf r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Divide by zero
    run_op("s-9/0 q", 1'b1, 1'b0, 32'hFFFF_FFF7, 32'd0, 32'h0000_0001);
    run_op("s-9/0 r", 1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
    run_op("u5/0 q", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("u5/0 r", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5);

    // Back-pressure in DONE with stray requests
    start_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
    wait_valid(cyc);
    check("hold latency", cyc, WIDTH + 2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~i[0];
      bus.src1     = $urandom;
      bus.src2     = $urandom;
      @(posedge clk); #1;
      check("hold out_valid", bus.out_valid, 32'd1);
      check("hold result", bus.result, 32'hFFFF_FFF2);
      check("hold in_ready", bus.in_ready, 32'd0);
    end
    // Handshake edge with a new request already waiting
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.src1      = 32'd81;
    bus.src2      = 32'd9;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hs idle", bus.busy, 32'd0);
    check("hs ready", bus.in_ready, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("next accept", bus.busy, 32'd1);
    wait_valid(cyc);
    check("next latency", cyc, WIDTH + 2);
    check("next result", bus.result, 32'd9);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Flush mid-iteration with a competing request
    start_op(1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (19) begin @(posedge clk); #1; end
    flush        = 1'b1;
    bus.src1     = 32'd50;
    bus.src2     = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush busy", bus.busy, 32'd0);
    check("flush out_valid", bus.out_valid, 32'd0);
    check("flush result", bus.result, 32'd0);
    check("flush in_ready", bus.in_ready, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= bus.out_valid | bus.busy;
    end
    check("flush no activity", {31'd0, seen}, 32'd0);
    run_op("after flush", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10);

    // Randomized operations against the model
    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op("random", s, r, a, b, ref_result(s, r, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
